// File: rtl/acc_stream_fifo_if.sv
// Stream interface between the data & control router and acc_stream_fifo.
// master : the side that drives put/get/flush (router or accelerator).
// slave  : the FIFO itself.
// Signals:
//   flush       master->slave  synchronous clear of contents
//   put_req     master->slave  write request, data_in sampled on the same edge
//   data_in     master->slave  write data
//   get_req     master->slave  read request
//   data_out    slave->master  registered read data
//   data_valid  slave->master  one-cycle pulse, data_out holds a newly read word
//   full/empty/almost_full     occupancy flags
//   count       slave->master  words stored, 0..2**ADDR_WIDTH
//   overflow    slave->master  sticky, a put was rejected while full
//   underflow   slave->master  sticky, a get was rejected while empty
interface acc_stream_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  put_req;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  get_req;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, put_req, data_in, get_req,
    input  data_out, data_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, put_req, data_in, get_req,
    output data_out, data_valid, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/acc_stream_fifo.sv
// Synchronous FIFO between the data & control router and one accelerator.
// Used twice per accelerator: a "to" FIFO (router fills, accelerator drains) and a
// "from" FIFO (accelerator fills, router drains). The occupancy flags let the router
// pause address generation and gate its put/get requests.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous active-high reset, overrides everything
//   io_bus   acc_stream_fifo_if.slave: flush, put/get handshake, data, flags, count, errors
module acc_stream_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  acc_stream_fifo_if.slave     io_bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AfullCnt = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_get_acc;
  logic                  w_put_acc;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Flags come from the explicit count, so full and empty never alias.
  assign w_full    = (r_count == DepthCnt);
  assign w_empty   = (r_count == '0);
  assign w_get_acc = io_bus.get_req & ~w_empty;
  // A simultaneous accepted get frees a slot, so a put into a full FIFO still lands.
  assign w_put_acc = io_bus.put_req & (~w_full | w_get_acc);

  always_comb begin
    w_count_next = r_count;
    case ({w_put_acc, w_get_acc})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage array is deliberately not cleared by reset or flush.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !io_bus.flush && w_put_acc) begin
      r_mem[r_wr_ptr] <= io_bus.data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (io_bus.flush) begin
      // Contents dropped; data_out and sticky errors are retained.
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_get_acc;
      r_count      <= w_count_next;
      if (w_put_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_get_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      if (io_bus.put_req && w_full && !w_get_acc) begin
        r_overflow <= 1'b1;
      end
      if (io_bus.get_req && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign io_bus.data_out    = r_data_out;
  assign io_bus.data_valid  = r_data_valid;
  assign io_bus.full        = w_full;
  assign io_bus.empty       = w_empty;
  assign io_bus.almost_full = (r_count >= AfullCnt);
  assign io_bus.count       = r_count;
  assign io_bus.overflow    = r_overflow;
  assign io_bus.underflow   = r_underflow;
endmodule

// File: tb/tb_acc_stream_fifo.sv
// Self-checking bench for acc_stream_fifo: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_acc_stream_fifo;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic clk;
  logic reset;

  acc_stream_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  acc_stream_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  bit            m_valid;
  bit            m_ovf;
  bit            m_unf;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit fl, input bit put,
                              input logic [DW-1:0] din, input bit get);
    bit ga;
    bit pa;
    if (rst) begin
      m_q.delete();
      m_dout  = '0;
      m_valid = 0;
      m_ovf   = 0;
      m_unf   = 0;
    end else if (fl) begin
      m_q.delete();
      m_valid = 0;
    end else begin
      ga = get && (m_q.size() != 0);
      pa = put && ((m_q.size() < DEPTH) || ga);
      if (get && m_q.size() == 0) m_unf = 1;
      if (put && !pa) m_ovf = 1;
      m_valid = ga;
      if (ga) m_dout = m_q.pop_front();
      if (pa) m_q.push_back(din);
    end
  endtask

  task automatic compare_all();
    int n;
    n = m_q.size();
    check_eq("count",       64'(bus.count),       64'(n));
    check_eq("full",        64'(bus.full),        64'(n == DEPTH));
    check_eq("empty",       64'(bus.empty),       64'(n == 0));
    check_eq("almost_full", 64'(bus.almost_full), 64'(n >= AFULL));
    check_eq("data_valid",  64'(bus.data_valid),  64'(m_valid));
    check_eq("data_out",    64'(bus.data_out),    64'(m_dout));
    check_eq("overflow",    64'(bus.overflow),    64'(m_ovf));
    check_eq("underflow",   64'(bus.underflow),   64'(m_unf));
  endtask

  // One clock cycle: drive on the falling edge, model on the rising edge, compare #1 later.
  task automatic step(input bit rst, input bit fl, input bit put,
                      input logic [DW-1:0] din, input bit get);
    @(negedge clk);
    reset       = rst;
    bus.flush   = fl;
    bus.put_req = put;
    bus.data_in = din;
    bus.get_req = get;
    @(posedge clk);
    model_update(rst, fl, put, din, get);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            put;
    bit            get;
    int            mode;

    reset       = 1'b0;
    bus.flush   = 1'b0;
    bus.put_req = 1'b0;
    bus.data_in = '0;
    bus.get_req = 1'b0;

    // Reset state.
    step(1, 0, 0, '0, 0);
    check_eq("rst_empty", 64'(bus.empty), 64'd1);
    check_eq("rst_count", 64'(bus.count), 64'd0);

    // 1: fill to full.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 32'hA000_0000 + 32'(i), 0);
      check_eq("t1_afull", 64'(bus.almost_full), 64'(i + 1 >= AFULL));
    end
    check_eq("t1_full", 64'(bus.full), 64'd1);
    check_eq("t1_count", 64'(bus.count), 64'd16);

    // 2: drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, '0, 1);
      check_eq("t2_dout", 64'(bus.data_out), 64'(32'hA000_0000 + 32'(i)));
      check_eq("t2_valid", 64'(bus.data_valid), 64'd1);
    end
    idle();
    check_eq("t2_empty", 64'(bus.empty), 64'd1);
    check_eq("t2_valid_drop", 64'(bus.data_valid), 64'd0);

    // 3: overflow while full.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'hB000_0000 + 32'(i), 0);
    step(0, 0, 1, 32'hDEAD_BEEF, 0);
    check_eq("t3_ovf", 64'(bus.overflow), 64'd1);
    check_eq("t3_count", 64'(bus.count), 64'd16);

    // 4: put and get together while full.
    step(0, 0, 1, 32'h1111_1111, 1);
    check_eq("t4_count", 64'(bus.count), 64'd16);
    check_eq("t4_dout", 64'(bus.data_out), 64'hB000_0000);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, '0, 1);
    check_eq("t4_last", 64'(bus.data_out), 64'h1111_1111);

    // 5: put and get together while empty.
    step(0, 0, 1, 32'h5, 1);
    check_eq("t5_unf", 64'(bus.underflow), 64'd1);
    check_eq("t5_count", 64'(bus.count), 64'd1);
    check_eq("t5_valid", 64'(bus.data_valid), 64'd0);
    step(0, 0, 0, '0, 1);
    check_eq("t5_dout", 64'(bus.data_out), 64'h5);

    // 6: wrap-around, mid-stream reset, flush.
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'hC000_0000 + 32'(i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'hD000_0000 + 32'(i), 0);
    check_eq("t6_count", 64'(bus.count), 64'd10);
    step(0, 0, 0, '0, 1);
    check_eq("t6_wrap_dout", 64'(bus.data_out), 64'hD000_0000);
    step(1, 0, 1, 32'h1234, 1);
    check_eq("t6_rst_count", 64'(bus.count), 64'd0);
    check_eq("t6_rst_empty", 64'(bus.empty), 64'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'hE000_0000 + 32'(i), 0);
    step(0, 0, 1, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, '0, 1);
    check_eq("t6_pre_flush", 64'(bus.count), 64'd7);
    step(0, 1, 1, 32'h77, 1);
    check_eq("t6_flush_count", 64'(bus.count), 64'd0);
    check_eq("t6_flush_ovf", 64'(bus.overflow), 64'd1);
    check_eq("t6_flush_dout", 64'(bus.data_out), 64'hE000_0008);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mode = (cyc / 48) % 3;
      d    = $urandom;
      case (mode)
        0:       begin put = ($urandom_range(0, 3) != 0); get = ($urandom_range(0, 3) == 0); end
        1:       begin put = ($urandom_range(0, 3) == 0); get = ($urandom_range(0, 3) != 0); end
        default: begin put = $urandom_range(0, 1) != 0;   get = $urandom_range(0, 1) != 0;   end
      endcase
      step($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0, put, d, get);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
